// File: rtl/dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_pkg
// Description : Shared types and constants for the dispatch stage: renamed
//               instruction format, dispatch payload, functional-unit
//               encodings and the functional-unit to reservation-station map.
// Revision    : 1.0 - initial release
// ============================================================================
package dispatch_pkg;

  localparam int NUM_PREGS = 128;
  localparam int PREG_W    = $clog2(NUM_PREGS);

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_BR  = 2'd1;
  localparam logic [1:0] FU_LSU = 2'd2;

  typedef struct packed {
    logic [7:0]        opcode;
    logic [1:0]        fu;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
  } rename_data;

  typedef struct packed {
    logic [7:0]        opcode;
    logic [1:0]        fu;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
    logic              ps1_ready;
    logic              ps2_ready;
  } dispatch_data;

  typedef enum logic [1:0] {
    TGT_ALU = 2'd0,
    TGT_BR  = 2'd1,
    TGT_LSU = 2'd2
  } target_e;

  // Unknown fu encodings fall back to the ALU station.
  function automatic target_e fu_target(input logic [1:0] fu);
    case (fu)
      FU_BR:   return TGT_BR;
      FU_LSU:  return TGT_LSU;
      default: return TGT_ALU;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_busy_table.sv
`default_nettype none
// ============================================================================
// Module      : busy_table
// Description : Physical-register busy bits. One set port (dispatch of a new
//               destination) and one clear port (writeback broadcast), plus
//               two readiness read ports that see a same-cycle writeback.
//               Register 0 is hard-wired not busy; set beats clear.
// Revision    : 1.0 - initial release
// ============================================================================
module busy_table
  import dispatch_pkg::*;
#(
  parameter int ENTRIES = NUM_PREGS,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_pd,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_pd,
  input  logic [IDX_W-1:0] rd1_pd,
  output logic             rd1_ready,
  input  logic [IDX_W-1:0] rd2_pd,
  output logic             rd2_ready
);

  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] busy_next;

  // Next-state: apply clear first so a coincident set of the same preg wins.
  always_comb begin
    busy_next = busy;
    if (clr_en && clr_pd != '0) busy_next[clr_pd] = 1'b0;
    if (set_en && set_pd != '0) busy_next[set_pd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  // Readiness with writeback bypass so a result broadcast this cycle counts.
  always_comb begin
    rd1_ready = (rd1_pd == '0) || !busy[rd1_pd] || (clr_en && clr_pd == rd1_pd);
    rd2_ready = (rd2_pd == '0) || !busy[rd2_pd] || (clr_en && clr_pd == rd2_pd);
  end

endmodule
`default_nettype wire

// File: rtl/dispatch.sv
`default_nettype none
// ============================================================================
// Module      : dispatch
// Description : Single-entry dispatch stage after rename. Holds one renamed
//               instruction, resolves operand readiness from the busy table,
//               and hands it to the ROB and one reservation station in the
//               same cycle. Mispredict flushes the held entry.
//               Optional macro DISPATCH_PERF_CNT_EN adds saturating stall
//               counters stall_rob_cnt and stall_rs_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch
  import dispatch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  rename_data        data_in,
  output logic              ready_in,
  input  logic              mispredict,
  input  logic              wb_valid,
  input  logic [PREG_W-1:0] wb_pd,
  output logic              rob_valid,
  input  logic              rob_ready,
  output logic              rs_alu_valid,
  output logic              rs_br_valid,
  output logic              rs_lsu_valid,
  input  logic              rs_alu_ready,
  input  logic              rs_br_ready,
  input  logic              rs_lsu_ready,
`ifdef DISPATCH_PERF_CNT_EN
  output logic [31:0]       stall_rob_cnt,
  output logic [31:0]       stall_rs_cnt,
`endif
  output dispatch_data      rs_data
);

  logic       valid_q;
  rename_data q;
  target_e    target;
  logic       target_ready;
  logic       live;
  logic       fire;
  logic       ps1_ready;
  logic       ps2_ready;

  // Target station and its readiness for the held instruction.
  always_comb begin
    target = fu_target(q.fu);
    case (target)
      TGT_BR:  target_ready = rs_br_ready;
      TGT_LSU: target_ready = rs_lsu_ready;
      default: target_ready = rs_alu_ready;
    endcase
  end

  // Handshake: ROB and RS requests each wait only on the other side, so the
  // entry is taken by both together or by neither. Mispredict kills all.
  always_comb begin
    live         = valid_q && !mispredict;
    fire         = live && rob_ready && target_ready;
    rob_valid    = live && target_ready;
    rs_alu_valid = live && rob_ready && (target == TGT_ALU);
    rs_br_valid  = live && rob_ready && (target == TGT_BR);
    rs_lsu_valid = live && rob_ready && (target == TGT_LSU);
    ready_in     = !mispredict && (!valid_q || fire);
  end

  // Holding register: flush, capture (possibly together with a fire), or drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (mispredict) begin
      valid_q <= 1'b0;
    end else if (valid_in && ready_in) begin
      valid_q <= 1'b1;
      q       <= data_in;
    end else if (fire) begin
      valid_q <= 1'b0;
    end
  end

  busy_table #(.ENTRIES(NUM_PREGS)) u_busy (
    .clk       (clk),
    .reset     (reset),
    .set_en    (fire),
    .set_pd    (q.pd_new),
    .clr_en    (wb_valid),
    .clr_pd    (wb_pd),
    .rd1_pd    (q.ps1),
    .rd1_ready (ps1_ready),
    .rd2_pd    (q.ps2),
    .rd2_ready (ps2_ready)
  );

  // Shared payload; zero when nothing is held.
  always_comb begin
    rs_data = '0;
    if (valid_q) begin
      rs_data.opcode    = q.opcode;
      rs_data.fu        = q.fu;
      rs_data.ps1       = q.ps1;
      rs_data.ps2       = q.ps2;
      rs_data.pd_new    = q.pd_new;
      rs_data.pd_old    = q.pd_old;
      rs_data.ps1_ready = ps1_ready;
      rs_data.ps2_ready = ps2_ready;
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  // Saturating stall counters, frozen during mispredict cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_rob_cnt <= '0;
      stall_rs_cnt  <= '0;
    end else if (!mispredict) begin
      if (valid_q && !rob_ready && stall_rob_cnt != '1)
        stall_rob_cnt <= stall_rob_cnt + 32'd1;
      if (valid_q && rob_ready && !target_ready && stall_rs_cnt != '1)
        stall_rs_cnt <= stall_rs_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch
// Description : Self-checking bench for dispatch: directed scenarios plus a
//               randomized run against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch;
  import dispatch_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  rename_data        data_in;
  logic              ready_in;
  logic              mispredict;
  logic              wb_valid;
  logic [PREG_W-1:0] wb_pd;
  logic              rob_valid;
  logic              rob_ready;
  logic              rs_alu_valid, rs_br_valid, rs_lsu_valid;
  logic              rs_alu_ready, rs_br_ready, rs_lsu_ready;
  dispatch_data      rs_data;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0]       stall_rob_cnt;
  logic [31:0]       stall_rs_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dispatch dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .ready_in     (ready_in),
    .mispredict   (mispredict),
    .wb_valid     (wb_valid),
    .wb_pd        (wb_pd),
    .rob_valid    (rob_valid),
    .rob_ready    (rob_ready),
    .rs_alu_valid (rs_alu_valid),
    .rs_br_valid  (rs_br_valid),
    .rs_lsu_valid (rs_lsu_valid),
    .rs_alu_ready (rs_alu_ready),
    .rs_br_ready  (rs_br_ready),
    .rs_lsu_ready (rs_lsu_ready),
`ifdef DISPATCH_PERF_CNT_EN
    .stall_rob_cnt(stall_rob_cnt),
    .stall_rs_cnt (stall_rs_cnt),
`endif
    .rs_data      (rs_data)
  );

  function automatic rename_data mk(input logic [1:0] fu, input logic [6:0] s1,
                                    input logic [6:0] s2, input logic [6:0] pd);
    rename_data d;
    d.opcode = 8'($urandom);
    d.fu     = fu;
    d.ps1    = s1;
    d.ps2    = s2;
    d.pd_new = pd;
    d.pd_old = 7'($urandom);
    return d;
  endfunction

  function automatic dispatch_data to_disp(input rename_data d, input logic r1, input logic r2);
    dispatch_data x;
    x.opcode = d.opcode; x.fu = d.fu; x.ps1 = d.ps1; x.ps2 = d.ps2;
    x.pd_new = d.pd_new; x.pd_old = d.pd_old; x.ps1_ready = r1; x.ps2_ready = r2;
    return x;
  endfunction

  task automatic idle();
    valid_in = 1'b0; data_in = '0; mispredict = 1'b0; wb_valid = 1'b0; wb_pd = '0;
    rob_ready = 1'b1; rs_alu_ready = 1'b1; rs_br_ready = 1'b1; rs_lsu_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input rename_data d);
    data_in = d; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  // Dispatch a probe reading preg p as ps1 and report its readiness.
  task automatic probe(input logic [6:0] p, output logic rdy);
    idle();
    send(mk(FU_ALU, p, 7'd0, 7'd0));
    #1 rdy = rs_data.ps1_ready;
    tick();
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1;
    #2;
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready_in got=%b want=1", ready_in); end
    checks++; if ({rob_valid, rs_alu_valid, rs_br_valid, rs_lsu_valid} !== 4'b0) begin errors++;
      $display("FAIL reset_valids got=%b want=0000", {rob_valid, rs_alu_valid, rs_br_valid, rs_lsu_valid}); end
    checks++; if (rs_data !== '0) begin errors++; $display("FAIL reset_rs_data got=%h want=0", rs_data); end
    tick(); reset = 1'b0; tick();
  endtask

  task automatic test_alu_basic();
    logic r;
    idle();
    data_in = mk(FU_ALU, 7'd5, 7'd0, 7'd40); valid_in = 1'b1;
    #1;
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL alu_accept ready_in got=%b want=1", ready_in); end
    tick(); valid_in = 1'b0; #1;
    checks++; if ({rob_valid, rs_alu_valid, rs_br_valid, rs_lsu_valid} !== 4'b1100) begin errors++;
      $display("FAIL alu_valids got=%b want=1100", {rob_valid, rs_alu_valid, rs_br_valid, rs_lsu_valid}); end
    checks++; if ({rs_data.ps1_ready, rs_data.ps2_ready} !== 2'b11) begin errors++;
      $display("FAIL alu_ps_ready got=%b want=11", {rs_data.ps1_ready, rs_data.ps2_ready}); end
    checks++; if (rs_data.pd_new !== 7'd40) begin errors++; $display("FAIL alu_pd_new got=%0d want=40", rs_data.pd_new); end
    tick();
    probe(7'd40, r);
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL alu_busy40 ready got=%b want=0", r); end
  endtask

  task automatic test_dependency_bypass();
    logic r;
    idle(); rob_ready = 1'b0;
    send(mk(FU_ALU, 7'd40, 7'd0, 7'd0));
    #1;
    checks++; if (rs_data.ps1_ready !== 1'b0) begin errors++; $display("FAIL dep_no_bypass got=%b want=0", rs_data.ps1_ready); end
    checks++; if ({rob_valid, rs_alu_valid} !== 2'b10) begin errors++;
      $display("FAIL dep_rob_stall valids got=%b want=10", {rob_valid, rs_alu_valid}); end
    wb_valid = 1'b1; wb_pd = 7'd40; #1;
    checks++; if (rs_data.ps1_ready !== 1'b1) begin errors++; $display("FAIL dep_bypass got=%b want=1", rs_data.ps1_ready); end
    rob_ready = 1'b1; #1;
    checks++; if (rs_alu_valid !== 1'b1) begin errors++; $display("FAIL dep_fire rs_alu_valid got=%b want=1", rs_alu_valid); end
    tick();
    probe(7'd40, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL dep_cleared ready got=%b want=1", r); end
  endtask

  task automatic test_lsu_stall();
    rename_data   d;
    dispatch_data exp;
    logic         r;
    idle(); rs_lsu_ready = 1'b0;
    d = mk(FU_LSU, 7'd3, 7'd4, 7'd70);
    exp = to_disp(d, 1'b1, 1'b1);
    send(d);
    data_in = mk(FU_ALU, 7'd0, 7'd0, 7'd71); valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({rs_lsu_valid, rob_valid, ready_in} !== 3'b100) begin errors++;
        $display("FAIL lsu_stall%0d lsu/rob/ready_in got=%b want=100", i, {rs_lsu_valid, rob_valid, ready_in}); end
      checks++; if (rs_data !== exp) begin errors++; $display("FAIL lsu_stall%0d payload got=%h want=%h", i, rs_data, exp); end
      tick();
    end
    valid_in = 1'b0; rs_lsu_ready = 1'b1; #1;
    checks++; if ({rs_lsu_valid, rob_valid, ready_in} !== 3'b111) begin errors++;
      $display("FAIL lsu_release lsu/rob/ready_in got=%b want=111", {rs_lsu_valid, rob_valid, ready_in}); end
    tick(); #1;
    checks++; if ({rob_valid, rs_alu_valid, rs_lsu_valid} !== 3'b000) begin errors++;
      $display("FAIL lsu_dropped valids got=%b want=000", {rob_valid, rs_alu_valid, rs_lsu_valid}); end
    probe(7'd70, r);
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL lsu_busy70 ready got=%b want=0", r); end
  endtask

  task automatic test_rob_stall_branch();
    idle(); rob_ready = 1'b0;
    send(mk(FU_BR, 7'd0, 7'd0, 7'd90));
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if ({rs_alu_valid, rs_br_valid, rs_lsu_valid, ready_in} !== 4'b0000) begin errors++;
        $display("FAIL br_rob_stall%0d rs/ready_in got=%b want=0000", i, {rs_alu_valid, rs_br_valid, rs_lsu_valid, ready_in}); end
      checks++; if (rob_valid !== 1'b1) begin errors++; $display("FAIL br_rob_stall%0d rob_valid got=%b want=1", i, rob_valid); end
      tick();
    end
  endtask

  // Continues from the branch left stalled by test_rob_stall_branch.
  task automatic test_mispredict();
    logic r;
    mispredict = 1'b1; valid_in = 1'b1; data_in = mk(FU_ALU, 7'd0, 7'd0, 7'd91);
    rob_ready = 1'b1; wb_valid = 1'b1; wb_pd = 7'd70;
    #1;
    checks++; if ({rob_valid, rs_alu_valid, rs_br_valid, rs_lsu_valid, ready_in} !== 5'b0) begin errors++;
      $display("FAIL misp_cycle valids/ready_in got=%b want=00000", {rob_valid, rs_alu_valid, rs_br_valid, rs_lsu_valid, ready_in}); end
    tick();
    idle(); #1;
    checks++; if ({rob_valid, rs_alu_valid, rs_br_valid, rs_lsu_valid, ready_in} !== 5'b00001) begin errors++;
      $display("FAIL misp_after valids/ready_in got=%b want=00001", {rob_valid, rs_alu_valid, rs_br_valid, rs_lsu_valid, ready_in}); end
    probe(7'd90, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL misp_busy90 ready got=%b want=1", r); end
    probe(7'd91, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL misp_busy91 ready got=%b want=1", r); end
    probe(7'd70, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL misp_wb_clear70 ready got=%b want=1", r); end
  endtask

  task automatic test_set_clear_collision();
    logic r;
    idle();
    send(mk(FU_ALU, 7'd0, 7'd0, 7'd60));
    wb_valid = 1'b1; wb_pd = 7'd60; #1;
    checks++; if (rs_alu_valid !== 1'b1) begin errors++; $display("FAIL coll_fire got=%b want=1", rs_alu_valid); end
    tick();
    probe(7'd60, r);
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL coll_set_wins ready got=%b want=0", r); end
  endtask

  task automatic test_reset_mid_stall();
    logic r;
    idle(); rob_ready = 1'b0;
    send(mk(FU_LSU, 7'd0, 7'd0, 7'd33));
    #2 reset = 1'b1; #1;
    checks++; if ({rob_valid, ready_in} !== 2'b01) begin errors++; $display("FAIL rst_stall rob/ready_in got=%b want=01", {rob_valid, ready_in}); end
    checks++; if (rs_data !== '0) begin errors++; $display("FAIL rst_stall rs_data got=%h want=0", rs_data); end
    tick(); reset = 1'b0; idle(); #1;
    checks++; if ({rob_valid, rs_lsu_valid} !== 2'b00) begin errors++;
      $display("FAIL rst_discard valids got=%b want=00", {rob_valid, rs_lsu_valid}); end
    probe(7'd60, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL rst_busy_clear ready got=%b want=1", r); end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 6; i++) begin
      data_in = mk(FU_ALU, 7'd0, 7'd0, 7'(100 + i)); valid_in = 1'b1; #1;
      checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL b2b%0d ready_in got=%b want=1", i, ready_in); end
      if (i > 0) begin
        checks++; if (rs_alu_valid !== 1'b1 || rs_data.pd_new !== 7'(99 + i)) begin errors++;
          $display("FAIL b2b%0d alu_valid=%b pd_new=%0d want 1/%0d", i, rs_alu_valid, rs_data.pd_new, 99 + i); end
      end
      tick();
    end
    valid_in = 1'b0; #1;
    checks++; if (rs_alu_valid !== 1'b1 || rs_data.pd_new !== 7'd105) begin errors++;
      $display("FAIL b2b_last alu_valid=%b pd_new=%0d want 1/105", rs_alu_valid, rs_data.pd_new); end
    tick();
  endtask

  // Reference model: one-slot buffer + busy array, driven by random traffic.
  task automatic test_random();
    bit           m_busy [NUM_PREGS];
    bit           m_valid;
    rename_data   m_q;
    logic         tr, live, e_fire, e_ready, r1, r2, is_br, is_lsu;
    logic [4:0]   e_vec, a_vec;
    dispatch_data exp;
    do_reset();
    foreach (m_busy[k]) m_busy[k] = 1'b0;
    m_valid = 1'b0; m_q = '0;
    for (int c = 0; c < 400; c++) begin
      valid_in     = ($urandom_range(9) < 7);
      data_in      = mk(2'($urandom), 7'($urandom_range(15)), 7'($urandom_range(15)), 7'($urandom_range(15)));
      mispredict   = ($urandom_range(19) == 0);
      wb_valid     = ($urandom_range(9) < 4);
      wb_pd        = 7'($urandom_range(15));
      rob_ready    = ($urandom_range(3) != 0);
      rs_alu_ready = ($urandom_range(3) != 0);
      rs_br_ready  = ($urandom_range(3) != 0);
      rs_lsu_ready = ($urandom_range(3) != 0);
      #1;
      is_br   = (m_q.fu == FU_BR);
      is_lsu  = (m_q.fu == FU_LSU);
      tr      = is_br ? rs_br_ready : (is_lsu ? rs_lsu_ready : rs_alu_ready);
      live    = m_valid && !mispredict;
      e_fire  = live && rob_ready && tr;
      e_ready = !mispredict && (!m_valid || e_fire);
      e_vec   = {e_ready, live && tr, live && rob_ready && !is_br && !is_lsu,
                 live && rob_ready && is_br, live && rob_ready && is_lsu};
      a_vec   = {ready_in, rob_valid, rs_alu_valid, rs_br_valid, rs_lsu_valid};
      checks++; if (a_vec !== e_vec) begin errors++;
        $display("FAIL rand%0d ready_in/rob/alu/br/lsu got=%b want=%b", c, a_vec, e_vec); end
      if (m_valid) begin
        r1  = (m_q.ps1 == 0) || !m_busy[m_q.ps1] || (wb_valid && wb_pd == m_q.ps1);
        r2  = (m_q.ps2 == 0) || !m_busy[m_q.ps2] || (wb_valid && wb_pd == m_q.ps2);
        exp = to_disp(m_q, r1, r2);
        checks++; if (rs_data !== exp) begin errors++;
          $display("FAIL rand%0d rs_data got=%h want=%h", c, rs_data, exp); end
      end
      if (wb_valid && wb_pd != 0) m_busy[wb_pd] = 1'b0;
      if (e_fire && m_q.pd_new != 0) m_busy[m_q.pd_new] = 1'b1;
      if (mispredict) m_valid = 1'b0;
      else if (valid_in && e_ready) begin m_valid = 1'b1; m_q = data_in; end
      else if (e_fire) m_valid = 1'b0;
      tick();
    end
    idle();
  endtask

`ifdef DISPATCH_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    checks++; if (stall_rob_cnt !== 32'd0 || stall_rs_cnt !== 32'd0) begin errors++;
      $display("FAIL perf_reset rob=%0d rs=%0d want 0/0", stall_rob_cnt, stall_rs_cnt); end
    rob_ready = 1'b0;
    send(mk(FU_BR, 7'd0, 7'd0, 7'd0));
    repeat (4) tick();
    checks++; if (stall_rob_cnt !== 32'd4) begin errors++; $display("FAIL perf_rob got=%0d want=4", stall_rob_cnt); end
    rob_ready = 1'b1; rs_br_ready = 1'b0;
    repeat (2) tick();
    mispredict = 1'b1; rob_ready = 1'b0;
    tick();
    mispredict = 1'b0; #1;
    checks++; if (stall_rob_cnt !== 32'd4 || stall_rs_cnt !== 32'd2) begin errors++;
      $display("FAIL perf_final rob=%0d rs=%0d want 4/2", stall_rob_cnt, stall_rs_cnt); end
    idle(); tick();
  endtask
`endif

  initial begin
    idle();
    reset = 1'b0;
    test_reset();
    test_alu_basic();
    test_dependency_bypass();
    test_lsu_stall();
    test_rob_stall_branch();
    test_mispredict();
    test_set_clear_collision();
    test_reset_mid_stall();
    test_back_to_back();
    test_random();
`ifdef DISPATCH_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
